// File: rtl/net_tx_arb_if.sv
// Stream bundle between the TX source channels, the arbiter and the MAC.
// The slave modport is the arbiter's view; master is the environment's view.
interface net_tx_arb_if #(
  parameter int CH_NUM     = 3,
  parameter int DATA_WIDTH = 8
);
  localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM*DATA_WIDTH-1:0] src_tdata_in;
  logic [CH_NUM-1:0]            src_tvalid_in;
  logic [CH_NUM-1:0]            src_tready_out;
  logic [CH_NUM-1:0]            src_tlast_in;
  logic [DATA_WIDTH-1:0]        net_tdata_out;
  logic                         net_tvalid_out;
  logic                         net_tready_in;
  logic                         net_tlast_out;
  logic [SEL_W-1:0]             net_tsel_out;
  logic                         net_busy_out;

  modport slave (
    input  src_tdata_in, src_tvalid_in, src_tlast_in, net_tready_in,
    output src_tready_out, net_tdata_out, net_tvalid_out, net_tlast_out,
    output net_tsel_out, net_busy_out
  );

  modport master (
    output src_tdata_in, src_tvalid_in, src_tlast_in, net_tready_in,
    input  src_tready_out, net_tdata_out, net_tvalid_out, net_tlast_out,
    input  net_tsel_out, net_busy_out
  );
endinterface

// File: rtl/net_tx_arb.sv
// Frame-atomic TX stream arbiter (fixed priority or round robin) feeding one MAC.
// Define NET_TX_IFG_EN to insert IFG_CYCLES idle cycles after every frame.
module net_tx_arb #(
  parameter int CH_NUM     = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ARB_MODE   = 0,
  parameter int IFG_CYCLES = 12
) (
  input logic         logic_clk,
  input logic         logic_rst,
  net_tx_arb_if.slave bus
);
  localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  if (CH_NUM < 2 || CH_NUM > 8 || ARB_MODE < 0 || ARB_MODE > 1 ||
      IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_cfg
    $error("net_tx_arb: parameter out of legal range");
  end

`ifdef NET_TX_IFG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;
  logic [7:0] gap_cnt;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;
`endif

  state_t              state;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W-1:0]    last_grant;
  logic [SEL_W-1:0]    pick;
  logic                last_hs;
  logic [DATA_WIDTH-1:0] ch_data [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign ch_data[g] = bus.src_tdata_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Winner among requesting channels; later loop iterations take precedence.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    if (ARB_MODE == 1) begin
      for (int k = CH_NUM; k >= 1; k--) begin
        idx  = int'(last_grant) + k;
        idx  = (idx >= CH_NUM) ? idx - CH_NUM : idx;
        pick = bus.src_tvalid_in[SEL_W'(idx)] ? SEL_W'(idx) : pick;
      end
    end else begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        pick = bus.src_tvalid_in[i] ? SEL_W'(i) : pick;
      end
    end
  end

  assign last_hs = (state == S_SEND) && bus.src_tvalid_in[grant] &&
                   bus.net_tready_in && bus.src_tlast_in[grant];

  // Frame-level FSM: grant is captured in IDLE and held until the tlast handshake.
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(CH_NUM - 1);
`ifdef NET_TX_IFG_EN
      gap_cnt    <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.src_tvalid_in) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (last_hs) begin
`ifdef NET_TX_IFG_EN
            state   <= S_GAP;
            gap_cnt <= 8'(IFG_CYCLES - 1);
`else
            state   <= S_IDLE;
`endif
          end
        end
`ifdef NET_TX_IFG_EN
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath mux: only the granted channel sees the MAC's ready, and only in SEND.
  always_comb begin
    bus.src_tready_out = '0;
    bus.net_tdata_out  = '0;
    bus.net_tvalid_out = 1'b0;
    bus.net_tlast_out  = 1'b0;
    if (state == S_SEND) begin
      bus.net_tdata_out         = ch_data[grant];
      bus.net_tvalid_out        = bus.src_tvalid_in[grant];
      bus.net_tlast_out         = bus.src_tlast_in[grant];
      bus.src_tready_out[grant] = bus.net_tready_in;
    end else begin
      bus.src_tready_out = '0;
      bus.net_tdata_out  = '0;
      bus.net_tvalid_out = 1'b0;
      bus.net_tlast_out  = 1'b0;
    end
  end

  assign bus.net_tsel_out = grant;
  assign bus.net_busy_out = (state != S_IDLE);
endmodule

// File: tb/tb_net_tx_arb.sv
// Scoreboard bench for net_tx_arb: one fixed-priority and one round-robin instance
// driven by queued frame sources, checked against a frame-order reference model.
module tb_net_tx_arb;
  localparam int CH  = 3;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int IFG = 12;
`ifdef NET_TX_IFG_EN
  localparam int EXP_GAP = IFG + 1;
`else
  localparam int EXP_GAP = 1;
`endif

  typedef struct packed { logic [DW-1:0] data; logic last; logic first; } beat_t;
  typedef struct packed { logic [SW-1:0] sel; logic [DW-1:0] data; logic last; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_v    [2];
  logic [CH*DW-1:0] tdata_v [2];
  logic [CH-1:0]   tvalid_v [2];
  logic [CH-1:0]   tlast_v  [2];
  logic            nready_v [2];
  logic [CH-1:0]   o_srdy   [2];
  logic [DW-1:0]   o_data   [2];
  logic            o_valid  [2];
  logic            o_last   [2];
  logic [SW-1:0]   o_sel    [2];
  logic            o_busy   [2];

  net_tx_arb_if #(.CH_NUM(CH), .DATA_WIDTH(DW)) bus0 ();
  net_tx_arb_if #(.CH_NUM(CH), .DATA_WIDTH(DW)) bus1 ();

  net_tx_arb #(.CH_NUM(CH), .DATA_WIDTH(DW), .ARB_MODE(0), .IFG_CYCLES(IFG)) dut0 (
    .logic_clk(clk), .logic_rst(rst_v[0]), .bus(bus0.slave));
  net_tx_arb #(.CH_NUM(CH), .DATA_WIDTH(DW), .ARB_MODE(1), .IFG_CYCLES(IFG)) dut1 (
    .logic_clk(clk), .logic_rst(rst_v[1]), .bus(bus1.slave));

  assign bus0.src_tdata_in  = tdata_v[0];
  assign bus0.src_tvalid_in = tvalid_v[0];
  assign bus0.src_tlast_in  = tlast_v[0];
  assign bus0.net_tready_in = nready_v[0];
  assign bus1.src_tdata_in  = tdata_v[1];
  assign bus1.src_tvalid_in = tvalid_v[1];
  assign bus1.src_tlast_in  = tlast_v[1];
  assign bus1.net_tready_in = nready_v[1];
  assign o_srdy[0]  = bus0.src_tready_out;
  assign o_data[0]  = bus0.net_tdata_out;
  assign o_valid[0] = bus0.net_tvalid_out;
  assign o_last[0]  = bus0.net_tlast_out;
  assign o_sel[0]   = bus0.net_tsel_out;
  assign o_busy[0]  = bus0.net_busy_out;
  assign o_srdy[1]  = bus1.src_tready_out;
  assign o_data[1]  = bus1.net_tdata_out;
  assign o_valid[1] = bus1.net_tvalid_out;
  assign o_last[1]  = bus1.net_tlast_out;
  assign o_sel[1]   = bus1.net_tsel_out;
  assign o_busy[1]  = bus1.net_busy_out;

  beat_t src_q    [2*CH][$];
  beat_t pend_b   [2*CH][$];
  int    pend_len [2*CH][$];
  exp_t  exp_q    [2][$];
  int    gap_q    [2][$];

  int            checks = 0;
  int            failures = 0;
  logic [CH-1:0] hs_src       [2];
  int            hs_cnt       [2];
  logic [SW-1:0] exp_last_sel [2];
  bit            gap_arm      [2];
  int            gap_cnt      [2];
  int            rdy_mode     [2];
  int            bubble_pct   [2];
  bit            tog          [2];
  int            model_rr     [2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: output rules every cycle, scoreboard pop on every MAC handshake.
  task automatic mon(input int d);
    logic [CH-1:0] oh;
    logic [CH-1:0] srdy;
    logic [DW-1:0] want;
    bit            bad;
    exp_t          e;
    if (rst_v[d]) begin
      hs_src[d]       = '0;
      exp_last_sel[d] = '0;
      gap_arm[d]      = 1'b0;
    end else begin
      srdy       = o_srdy[d];
      oh         = CH'(1) << o_sel[d];
      hs_src[d]  = tvalid_v[d] & srdy;
      bad        = 1'b0;
      if (!o_busy[d]) begin
        bad = (srdy != '0) || o_valid[d] || o_last[d] || (o_data[d] != '0) ||
              (o_sel[d] != exp_last_sel[d]);
      end else if (o_valid[d]) begin
        want = tdata_v[d][int'(o_sel[d])*DW +: DW];
        bad  = (srdy != (oh & {CH{nready_v[d]}})) || !tvalid_v[d][o_sel[d]] ||
               (o_data[d] != want) || (o_last[d] != tlast_v[d][o_sel[d]]);
      end else begin
        bad = ((srdy & ~oh) != '0) || ((srdy != '0) && !nready_v[d]);
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL output_rules dut%0d t=%0t actual busy=%b valid=%b last=%b sel=%0d data=%h src_ready=%b net_ready=%b src_valid=%b required idle-zero outputs, held sel=%0d, ready only on granted channel",
                 d, $time, o_busy[d], o_valid[d], o_last[d], o_sel[d], o_data[d], srdy,
                 nready_v[d], tvalid_v[d], exp_last_sel[d]);
      end
      if (gap_arm[d]) begin
        if (o_valid[d]) begin
          gap_q[d].push_back(gap_cnt[d]);
          gap_arm[d] = 1'b0;
        end else begin
          gap_cnt[d]++;
        end
      end
      if (o_valid[d] && nready_v[d]) begin
        hs_cnt[d]++;
        checks++;
        if (exp_q[d].size() == 0) begin
          failures++;
          $display("FAIL beat dut%0d actual sel=%0d data=%h last=%b required no beat",
                   d, o_sel[d], o_data[d], o_last[d]);
        end else begin
          e = exp_q[d].pop_front();
          exp_last_sel[d] = e.sel;
          if ({o_sel[d], o_data[d], o_last[d]} != {e.sel, e.data, e.last}) begin
            failures++;
            $display("FAIL beat dut%0d actual sel=%0d data=%h last=%b required sel=%0d data=%h last=%b",
                     d, o_sel[d], o_data[d], o_last[d], e.sel, e.data, e.last);
          end
        end
        if (o_last[d]) begin
          gap_arm[d] = 1'b1;
          gap_cnt[d] = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic drive_all();
    beat_t b;
    bit    bub;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (src_q[d*CH+c].size() > 0) begin
          b   = src_q[d*CH+c][0];
          bub = !b.first && (bubble_pct[d] > 0) && ($urandom_range(0, 99) < bubble_pct[d]);
          tvalid_v[d][c]           = !bub;
          tlast_v[d][c]            = b.last;
          tdata_v[d][c*DW +: DW]   = b.data;
        end else begin
          tvalid_v[d][c]           = 1'b0;
          tlast_v[d][c]            = 1'b0;
          tdata_v[d][c*DW +: DW]   = DW'($urandom);
        end
      end
      case (rdy_mode[d])
        1:       nready_v[d] = ($urandom_range(0, 99) < 70);
        2:       nready_v[d] = tog[d];
        default: nready_v[d] = 1'b1;
      endcase
    end
  endtask

  task automatic cycle();
    beat_t b;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        for (int c = 0; c < CH; c++) src_q[d*CH+c].delete();
        exp_q[d].delete();
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (hs_src[d][c] && src_q[d*CH+c].size() > 0) b = src_q[d*CH+c].pop_front();
        end
      end
      tog[d] = !tog[d];
    end
    drive_all();
  endtask

  task automatic add_frame(input int d, input int c, input int len);
    beat_t b;
    pend_len[d*CH+c].push_back(len);
    for (int i = 0; i < len; i++) begin
      b.data  = DW'($urandom);
      b.last  = (i == len - 1);
      b.first = (i == 0);
      pend_b[d*CH+c].push_back(b);
    end
  endtask

  // Reference model: replay the arbitration rule over whole frames that are all
  // pending at once, producing the beat order the MAC must see.
  task automatic commit(input int d);
    int    rem [CH];
    int    win;
    int    j;
    int    len;
    beat_t b;
    exp_t  e;
    for (int c = 0; c < CH; c++) rem[c] = pend_len[d*CH+c].size();
    forever begin
      win = -1;
      if (d == 0) begin
        for (int c = 0; c < CH && win < 0; c++) if (rem[c] > 0) win = c;
      end else begin
        for (int s = 1; s <= CH && win < 0; s++) begin
          j = (model_rr[d] + s) % CH;
          if (rem[j] > 0) win = j;
        end
      end
      if (win < 0) break;
      model_rr[d] = win;
      rem[win]--;
      len = pend_len[d*CH+win].pop_front();
      for (int i = 0; i < len; i++) begin
        b = pend_b[d*CH+win].pop_front();
        src_q[d*CH+win].push_back(b);
        e.sel  = SW'(win);
        e.data = b.data;
        e.last = b.last;
        exp_q[d].push_back(e);
      end
    end
    drive_all();
  endtask

  function automatic bit pending(input int d);
    bit p = (exp_q[d].size() > 0);
    for (int c = 0; c < CH; c++) p = p || (src_q[d*CH+c].size() > 0);
    return p;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((pending(0) || pending(1)) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk("drain_timeout", n, -1);
    repeat (IFG + 4) cycle();
    chk("idle_after_drain_dut0", int'(o_busy[0]), 0);
    chk("idle_after_drain_dut1", int'(o_busy[1]), 0);
  endtask

  task automatic clr_gaps(input int d);
    gap_q[d].delete();
    gap_arm[d] = 1'b0;
    gap_cnt[d] = 0;
  endtask

  initial begin
    int base;
    int n;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; hs_src[d] = '0; hs_cnt[d] = 0; exp_last_sel[d] = '0;
      gap_arm[d] = 1'b0; gap_cnt[d] = 0; rdy_mode[d] = 0; bubble_pct[d] = 0;
      tog[d] = 1'b0; model_rr[d] = CH - 1;
    end
    drive_all();
    repeat (3) cycle();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", int'(o_busy[d]), 0);
      chk("reset_valid", int'(o_valid[d]), 0);
      chk("reset_sel", int'(o_sel[d]), 0);
      chk("reset_src_ready", int'(o_srdy[d]), 0);
      chk("reset_data_last", int'({o_data[d], o_last[d]}), 0);
    end

    // Fixed priority: ch0 and ch2 together, ch0 frame first.
    clr_gaps(0);
    add_frame(0, 0, 4);
    add_frame(0, 2, 4);
    commit(0);
    drain(400);
    chk("prio_gap_count", gap_q[0].size(), 1);
    if (gap_q[0].size() > 0) chk("prio_gap_len", gap_q[0][0], EXP_GAP);

    // Round robin: three channels, two 2-beat frames each, continuous valid.
    clr_gaps(1);
    for (int r = 0; r < 2; r++) for (int c = 0; c < CH; c++) add_frame(1, c, 2);
    commit(1);
    drain(600);
    chk("rr_gap_count", gap_q[1].size(), 5);
    foreach (gap_q[1][i]) chk("rr_gap_len", gap_q[1][i], EXP_GAP);

    // Toggling MAC ready during a 5-beat ch1 frame.
    rdy_mode[0] = 2;
    tog[0] = 1'b0;
    base = hs_cnt[0];
    add_frame(0, 1, 5);
    commit(0);
    drain(400);
    chk("toggle_beats", hs_cnt[0] - base, 5);
    rdy_mode[0] = 0;

    // ch1 requests in the middle of a ch0 frame.
    clr_gaps(0);
    add_frame(0, 0, 4);
    commit(0);
    cycle();
    cycle();
    add_frame(0, 1, 3);
    commit(0);
    drain(400);
    chk("late_req_gap_count", gap_q[0].size(), 1);
    if (gap_q[0].size() > 0) chk("late_req_gap_len", gap_q[0][0], EXP_GAP);

    // Reset while beat 3 of a 6-beat frame is on the bus.
    base = hs_cnt[0];
    add_frame(0, 0, 6);
    commit(0);
    n = 0;
    while (hs_cnt[0] < base + 2 && n < 100) begin
      cycle();
      n++;
    end
    chk("reset_frame_reached_beat3", hs_cnt[0] - base, 2);
    rst_v[0] = 1'b1;
    cycle();
    rst_v[0] = 1'b0;
    drive_all();
    chk("midreset_valid", int'(o_valid[0]), 0);
    chk("midreset_busy", int'(o_busy[0]), 0);
    chk("midreset_sel", int'(o_sel[0]), 0);
    base = hs_cnt[0];
    add_frame(0, 2, 2);
    commit(0);
    drain(400);
    chk("post_reset_beats", hs_cnt[0] - base, 2);

    // Randomised traffic on both instances, including single-beat frames.
    for (int d = 0; d < 2; d++) begin
      rdy_mode[d] = 1;
      bubble_pct[d] = 25;
    end
    for (int r = 0; r < 25; r++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < CH; c++) begin
          n = $urandom_range(0, 2);
          for (int f = 0; f < n; f++) add_frame(d, c, $urandom_range(1, 6));
        end
        commit(d);
      end
      drain(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
